// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_if.sv
// Handshake and data bundle between a requester and serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

`ifdef SERIAL_ADD_OVF_EN
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Single-bit full adder used as the only arithmetic cell of the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one result bit per clock, LSB first, through one fa_cell.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_add_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic fa_s;
    logic fa_co;

    fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result fills from the top so bit 0 lands in place after WIDTH shifts.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this last step.
                    ovf_d   = carry_q ^ fa_co;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): timeline model plus directed literals.
// Checks ovf as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_err = 0;
    int   dut_dones = 0;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: k = edges since the accepting edge (-1 when idle); result from plain arithmetic.
    int             k = -1;
    logic [W-1:0]   m_sum = '0;
    logic           m_cout = 1'b0;
    logic           m_ovf = 1'b0;
    logic [W:0]     full;
    int             s_signed;

    always_comb begin
        full     = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
        s_signed = int'($signed(bus.a)) + int'($signed(bus.b)) + int'(bus.cin);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= -1;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (k == -1 && bus.start) begin
            k      <= 0;
            m_sum  <= full[W-1:0];
            m_cout <= full[W];
            m_ovf  <= (s_signed > (2**(W-1)) - 1) || (s_signed < -(2**(W-1)));
        end else if (k >= W) begin
            k <= -1;
        end else if (k >= 0) begin
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (bus.done) dut_dones++;
        check("m_busy", {63'd0, bus.busy}, {63'd0, (k >= 0 && k < W)});
        check("m_done", {63'd0, bus.done}, {63'd0, (k == W)});
        if (!(k >= 0 && k < W)) begin
            check("m_sum", {56'd0, bus.sum}, {56'd0, m_sum});
            check("m_cout", {63'd0, bus.cout}, {63'd0, m_cout});
`ifdef SERIAL_ADD_OVF_EN
            check("m_ovf", {63'd0, bus.ovf}, {63'd0, m_ovf});
`endif
        end
    end

    task automatic wait_done(input string nm, output int lat, output int bcnt);
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcnt++;
        end
        if (!bus.done) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", nm);
        end
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic [W-1:0] es, input logic ec, input string nm,
                      output int lat, output int bcnt);
        @(negedge clk);
        bus.a = ta; bus.b = tb_v; bus.cin = tc; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(nm, lat, bcnt);
        check({nm, "_sum"}, {56'd0, bus.sum}, {56'd0, es});
        check({nm, "_cout"}, {63'd0, bus.cout}, {63'd0, ec});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat, bcnt, d0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
        #2;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_sum", {56'd0, bus.sum}, 64'd0);
        check("rst_cout", {63'd0, bus.cout}, 64'd0);
        // Start held during reset must not be accepted.
        bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1 check("no_accept_in_reset", {63'd0, bus.busy}, 64'd0);

        op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, "add_0f_01", lat, bcnt);
        check("latency", lat, 64'd8);
        check("busy_cycles", bcnt, 64'd8);
        op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_ff_01", lat, bcnt);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf_ff_01", {63'd0, bus.ovf}, 64'd0);
`endif
        op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "add_7f_01", lat, bcnt);
`ifdef SERIAL_ADD_OVF_EN
        check("ovf_7f_01", {63'd0, bus.ovf}, 64'd1);
`endif
        op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "add_cin_only", lat, bcnt);
        op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_ff_ff_1", lat, bcnt);

        // Start and operand changes during RUN are ignored.
        d0 = dut_dones;
        @(negedge clk);
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h55;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.a = 8'hFF; bus.b = 8'hFF;
        wait_done("ignore_start", lat, bcnt);
        check("ignore_sum", {56'd0, bus.sum}, 64'h46);
        check("ignore_cout", {63'd0, bus.cout}, 64'd0);
        repeat (12) @(posedge clk);
        #1 check("ignore_one_done", dut_dones - d0, 64'd1);

        // Asynchronous reset in the fourth RUN cycle aborts with no done.
        @(negedge clk);
        bus.a = 8'h3C; bus.b = 8'h05; bus.cin = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        check("abort_sum", {56'd0, bus.sum}, 64'd0);
        check("abort_cout", {63'd0, bus.cout}, 64'd0);
        d0 = dut_dones;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 check("abort_no_done", dut_dones - d0, 64'd0);
        op(8'h3C, 8'h05, 1'b1, 8'h42, 1'b0, "after_abort", lat, bcnt);

        // Back-to-back with start held high and random operands.
        d0 = dut_dones;
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 0; i < 1000 * (W + 2); i++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.cin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (W + 4) @(negedge clk);
        check("b2b_done_count", dut_dones - d0, 64'd1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 SHALL have a  input  WIDTH  operand A, captured when start accepted.
REQ-006 SHALL have b  input  WIDTH  operand B, captured when start accepted.
REQ-007 SHALL have cin  input  1  carry-in, captured when start accepted.
REQ-008 SHALL have busy  output  1  high while bits are being processed.
REQ-009 SHALL have done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have sum  output  WIDTH  result A+B+cin modulo 2^WIDTH.
REQ-011 SHALL have cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 SHALL compute the sum bit-serially, LSB first, one bit per clock, through a single 1-bit full-adder cell.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; encoding from shared package.
REQ-014 IDLE: start=1 SHALL load a, b into shift registers, cin into carry flop, clear bit counter, go to RUN.
REQ-015 RUN: each edge SHALL shift in the cell's sum bit at the result MSB, shift operands right, register the cell's carry, increment counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge completing bit WIDTH-1 SHALL go to DONE.
REQ-017 DONE: done=1 for exactly one cycle, then unconditionally to IDLE.
REQ-018 done SHALL first be high WIDTH edges after the edge that accepted start (latency WIDTH+1 cycles start-to-done-cycle inclusive).
REQ-019 busy SHALL equal (state==RUN); busy and done never high together.
REQ-020 start SHALL be ignored in RUN and DONE; operands change during RUN SHALL not affect the result.
REQ-021 sum and cout SHALL hold the last result stable from done until the next accepted start, and SHALL not be valid while busy.
REQ-022 Back-to-back: start held high continuously SHALL yield one addition per WIDTH+2 cycles.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0, independent of clk.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; first start after release begins a fresh addition.
REQ-025 start SHALL not be accepted on the edge coinciding with rst_n low.

Configuration
REQ-026 Macro SERIAL_ADD_OVF_EN defined: SHALL add output ovf (1 bit) = two's-complement signed overflow (carry into MSB XOR carry out of MSB), registered and held like sum, reset 0.
REQ-027 Macro SERIAL_ADD_OVF_EN undefined: ovf port and its logic SHALL not exist; all other behaviour identical.

Structure
REQ-028 Shared package serial_add_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 The 1-bit adder SHALL be a separate sub-module fa_cell (inputs a, b, cin; outputs s, cout; purely combinational), instantiated once.
REQ-030 Counter width SHALL be $clog2(WIDTH)+1 bits or wider to avoid wrap.

Verification (WIDTH=8)
REQ-031 a=0x0F, b=0x01, cin=0, start pulse -> done 8 edges later, sum=0x10, cout=0, busy high 8 cycles.
REQ-032 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; with SERIAL_ADD_OVF_EN ovf=0; a=0x7F, b=0x01 -> sum=0x80, ovf=1.
REQ-033 a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-034 start pulse during RUN with different a/b -> ignored, single done, result of first operands.
REQ-035 rst_n low at RUN cycle 4 -> all outputs 0 asynchronously, no done; new start after release -> correct result.
REQ-036 Random a, b, cin over 1000 transactions with start held high -> sum/cout match reference model, one done per WIDTH+2 cycles.
